// File: rtl/alu_control_mc.sv
// alu_control_mc: registered ALU control decode with a busy/stall sequencer for multi-cycle MUL/DIV ops.
module alu_control_mc #(
   parameter int CTRL_W  = 4,
   parameter int EN_M    = 1,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 33
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [9:0]        funct_i,
   input  logic [1:0]        ALUOp_i,
   input  logic              valid_i,
   input  logic              flush_i,
   output logic              ready_o,
   output logic              stall_o,
   output logic [CTRL_W-1:0] ALUCtrl_o,
   output logic              valid_o,
   output logic              start_o,
   output logic              busy_o,
   output logic              illegal_o
);
   localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [CTRL_W-1:0] ctrl_nx;
   logic              valid_nx, start_nx, ill_nx;
   logic [6:0]        f7;
   logic [2:0]        f3;
   logic [3:0]        base, code;
   logic              ill, multi, accept, done;

   assign f7      = funct_i[9:3];
   assign f3      = funct_i[2:0];
   assign ready_o = state == IDLE;
   assign busy_o  = state == BUSY;
   assign stall_o = valid_i & ~ready_o;
   assign accept  = valid_i & ready_o & ~flush_i;
   assign done    = busy_o && cnt == '0;
   assign multi   = code >= 4'hA;

   // funct3 order: ADD SLL SLT SLTU XOR SRL OR AND, shared by R and I forms
   always_comb begin
      base = 4'h0;
      case (f3)
         3'b001:  base = 4'h5;
         3'b010:  base = 4'h8;
         3'b011:  base = 4'h9;
         3'b100:  base = 4'h4;
         3'b101:  base = 4'h6;
         3'b110:  base = 4'h3;
         3'b111:  base = 4'h2;
         default: base = 4'h0;
      endcase
   end

   // illegal decodes leave code at ADD
   always_comb begin
      code = 4'h0;
      ill  = 1'b0;
      case (ALUOp_i)
         2'b00: code = 4'h0;
         2'b01: code = 4'h1;
         2'b10: begin
            if (f7 == 7'b0000000) code = base;
            else if (f7 == 7'b0100000 && f3 == 3'b000) code = 4'h1;
            else if (f7 == 7'b0100000 && f3 == 3'b101) code = 4'h7;
            else if (f7 == 7'b0000001 && EN_M != 0 && f3[2:1] != 2'b01)
               code = f3[2] ? {2'b11, f3[1:0]} : {3'b101, f3[0]};
            else ill = 1'b1;
         end
         default: begin
            if ((f3 == 3'b001 || f3 == 3'b101) && f7 != 7'b0000000) begin
               if (f3 == 3'b101 && f7 == 7'b0100000) code = 4'h7;
               else ill = 1'b1;
            end else code = base;
         end
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ctrl_nx  = ALUCtrl_o;
      valid_nx = 1'b0;
      start_nx = 1'b0;
      ill_nx   = 1'b0;
      if (flush_i) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else if (accept) begin
         ctrl_nx  = CTRL_W'(code);
         ill_nx   = ill;
         start_nx = multi;
         valid_nx = ~multi;
         state_nx = multi ? BUSY : IDLE;
         cnt_nx   = !multi ? '0 : code >= 4'hC ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
      end else if (busy_o) begin
         valid_nx = done;
         state_nx = done ? IDLE : BUSY;
         cnt_nx   = done ? cnt : cnt - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         ALUCtrl_o <= '0;
         valid_o   <= 1'b0;
         start_o   <= 1'b0;
         illegal_o <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         ALUCtrl_o <= ctrl_nx;
         valid_o   <= valid_nx;
         start_o   <= start_nx;
         illegal_o <= ill_nx;
      end
   end
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: directed and random checks of alu_control_mc against a remaining-cycles model.
module tb_alu_control_mc;
   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 33;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [9:0] funct_i;
   logic [1:0] ALUOp_i;
   logic       valid_i, flush_i;
   logic       ready, stall, valid, start, busy, ill;
   logic [3:0] ctrl;
   logic       n_ready, n_stall, n_valid, n_start, n_busy, n_ill;
   logic [3:0] n_ctrl;
   logic [9:0] act;

   int n_vec = 0;
   int n_bad = 0;

   logic [3:0] m_ctrl;
   bit         m_valid, m_start, m_ill;
   int         rem;

   always #5 clk = ~clk;

   alu_control_mc #(.CTRL_W(4), .EN_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk_i(clk), .rst_i(rst_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i), .valid_i(valid_i),
      .flush_i(flush_i), .ready_o(ready), .stall_o(stall), .ALUCtrl_o(ctrl), .valid_o(valid),
      .start_o(start), .busy_o(busy), .illegal_o(ill)
   );

   alu_control_mc #(.CTRL_W(4), .EN_M(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) nom (
      .clk_i(clk), .rst_i(rst_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i), .valid_i(valid_i),
      .flush_i(flush_i), .ready_o(n_ready), .stall_o(n_stall), .ALUCtrl_o(n_ctrl), .valid_o(n_valid),
      .start_o(n_start), .busy_o(n_busy), .illegal_o(n_ill)
   );

   assign act = {ctrl, valid, start, busy, ill, ready, stall};

   function automatic void dec(input logic [1:0] op, input logic [9:0] f, input bit enm,
                               output int code, output bit il);
      int rtab[8];
      int f7, f3;
      rtab = '{0, 5, 8, 9, 4, 6, 3, 2};
      f7 = int'(f[9:3]);
      f3 = int'(f[2:0]);
      code = 0;
      il = 0;
      if (op == 2'b00) code = 0;
      else if (op == 2'b01) code = 1;
      else if (op == 2'b10) begin
         if (f7 == 0) code = rtab[f3];
         else if (f7 == 32 && f3 == 0) code = 1;
         else if (f7 == 32 && f3 == 5) code = 7;
         else if (f7 == 1 && enm && f3 != 2 && f3 != 3) code = 10 + (f3 < 2 ? f3 : f3 - 2);
         else il = 1;
      end else begin
         if (f3 == 1) begin if (f7 == 0) code = 5; else il = 1; end
         else if (f3 == 5) begin
            if (f7 == 0) code = 6;
            else if (f7 == 32) code = 7;
            else il = 1;
         end else code = rtab[f3];
      end
      if (il) code = 0;
   endfunction

   function automatic logic [9:0] expv();
      return {m_ctrl, m_valid, m_start, rem > 0, m_ill, rem == 0, valid_i && rem != 0};
   endfunction

   task automatic model_reset();
      m_ctrl = 4'h0;
      m_valid = 0;
      m_start = 0;
      m_ill = 0;
      rem = 0;
   endtask

   task automatic step(input bit v, input bit fl, input logic [1:0] op, input logic [9:0] f);
      int c, lat;
      bit il;
      valid_i = v;
      flush_i = fl;
      ALUOp_i = op;
      funct_i = f;
      @(posedge clk);
      if (fl) begin
         rem = 0; m_valid = 0; m_start = 0; m_ill = 0;
      end else if (rem > 0) begin
         rem--;
         m_valid = rem == 0; m_start = 0; m_ill = 0;
      end else if (v) begin
         dec(op, f, 1, c, il);
         lat = c >= 12 ? DIV_LAT : c >= 10 ? MUL_LAT : 0;
         m_ctrl = 4'(c); m_ill = il; rem = lat;
         m_start = lat > 0; m_valid = lat == 0;
      end else begin
         m_valid = 0; m_start = 0; m_ill = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 2'b00, 10'h0);
   endtask

   task automatic test_reset();
      rst_i = 0; valid_i = 0; flush_i = 0; ALUOp_i = 0; funct_i = 0;
      model_reset();
      @(negedge clk);
      n_vec++;
      if (act !== expv()) begin n_bad++; $display("FAIL reset_state: got %h expected %h", act, expv()); end
      rst_i = 1;
      step(1, 0, 2'b10, {7'd1, 3'd4});
      idle(3);
      n_vec++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL div_busy_before_reset: got %b expected 1", busy); end
      rst_i = 0;
      #1;
      model_reset();
      n_vec++;
      if ({busy, ready, ctrl} !== {1'b0, 1'b1, 4'h0}) begin
         n_bad++; $display("FAIL async_reset: got busy=%b ready=%b ctrl=%h expected 0 1 0", busy, ready, ctrl);
      end
      #2 rst_i = 1;
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 2'b00, 10'h0);
         n_vec++;
         if (valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: cycle %0d got %b expected 0", i, valid); end
      end
   endtask

   task automatic test_rtype_b2b();
      logic [9:0] fs[3] = '{10'b0000000000, 10'b0100000000, 10'b0100000101};
      logic [3:0] want[3] = '{4'h0, 4'h1, 4'h7};
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 2'b10, fs[i]);
         n_vec++;
         if ({ctrl, valid, ready, ill} !== {want[i], 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rtype_b2b[%0d]: got ctrl=%h valid=%b ready=%b ill=%b expected %h 1 1 0", i, ctrl, valid, ready, ill, want[i]);
         end
      end
      idle(1);
   endtask

   task automatic test_itype();
      logic [1:0] ops[4] = '{2'b11, 2'b11, 2'b11, 2'b00};
      logic [9:0] fs[4]  = '{10'b0100000101, 10'b0100000000, 10'b0100000001, 10'b0100000101};
      logic [3:0] want[4] = '{4'h7, 4'h0, 4'h0, 4'h0};
      bit         wil[4] = '{0, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
         step(1, 0, ops[i], fs[i]);
         n_vec++;
         if ({ctrl, valid, ill} !== {want[i], 1'b1, wil[i]}) begin
            n_bad++;
            $display("FAIL itype[%0d]: got ctrl=%h valid=%b ill=%b expected %h 1 %b", i, ctrl, valid, ill, want[i], wil[i]);
         end
      end
      idle(1);
   endtask

   task automatic test_mul();
      int stalls, valids;
      step(1, 0, 2'b10, 10'b0000001000);
      n_vec++;
      if ({ctrl, start, busy, ready} !== {4'hA, 1'b1, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL mul_accept: got ctrl=%h start=%b busy=%b ready=%b expected a 1 1 0", ctrl, start, busy, ready);
      end
      stalls = int'(stall);
      valids = 0;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 2'b10, 10'b0000001000);
         stalls += int'(stall);
         valids += int'(valid);
         n_vec++;
         if (start !== 1'b0) begin n_bad++; $display("FAIL mul_start_pulse: cycle %0d got %b expected 0", i, start); end
      end
      n_vec++;
      if ({valid, ready, stalls, valids} !== {1'b1, 1'b1, 32'd3, 32'd1}) begin
         n_bad++; $display("FAIL mul_done: got valid=%b ready=%b stalls=%0d valids=%0d expected 1 1 3 1", valid, ready, stalls, valids);
      end
      step(1, 0, 2'b10, 10'b0000001000);
      n_vec++;
      if ({ctrl, start, busy} !== {4'hA, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL mul_second_accept: got ctrl=%h start=%b busy=%b expected a 1 1", ctrl, start, busy);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 2'b00, 10'h0);
         n_vec++;
         if (act !== expv()) begin n_bad++; $display("FAIL mul_drain[%0d]: got %h expected %h", i, act, expv()); end
      end
   endtask

   task automatic test_flush();
      int seen;
      step(1, 0, 2'b10, 10'b0000001101);
      n_vec++;
      if ({ctrl, start} !== {4'hD, 1'b1}) begin n_bad++; $display("FAIL divu_accept: got ctrl=%h start=%b expected d 1", ctrl, start); end
      idle(4);
      step(0, 1, 2'b00, 10'h0);
      n_vec++;
      if ({busy, ready, valid, start, ctrl} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'hD}) begin
         n_bad++; $display("FAIL flush_busy: got busy=%b ready=%b valid=%b start=%b ctrl=%h expected 0 1 0 0 d", busy, ready, valid, start, ctrl);
      end
      seen = 0;
      for (int i = 0; i < 35; i++) begin
         step(0, 0, 2'b00, 10'h0);
         seen += int'(valid);
      end
      n_vec++;
      if (seen != 0) begin n_bad++; $display("FAIL flush_no_valid: got %0d valid cycles expected 0", seen); end
      step(1, 1, 2'b01, 10'h0);
      n_vec++;
      if ({valid, ctrl, busy} !== {1'b0, 4'hD, 1'b0}) begin
         n_bad++; $display("FAIL flush_idle_accept: got valid=%b ctrl=%h busy=%b expected 0 d 0", valid, ctrl, busy);
      end
      idle(1);
   endtask

   task automatic test_enm();
      int c;
      bit il;
      dec(2'b10, 10'b0000001000, 0, c, il);
      step(1, 0, 2'b10, 10'b0000001000);
      n_vec++;
      if ({n_ctrl, n_valid, n_start, n_busy, n_ill} !== {4'(c), 1'b1, 1'b0, 1'b0, il}) begin
         n_bad++;
         $display("FAIL enm0_mul: got ctrl=%h valid=%b start=%b busy=%b ill=%b expected %h 1 0 0 %b", n_ctrl, n_valid, n_start, n_busy, n_ill, 4'(c), il);
      end
      n_vec++;
      if ({ctrl, start} !== {4'hA, 1'b1}) begin n_bad++; $display("FAIL enm1_mul: got ctrl=%h start=%b expected a 1", ctrl, start); end
      idle(3);
      step(1, 0, 2'b10, 10'b0000001011);
      n_vec++;
      if ({ctrl, valid, ill, start} !== {4'h0, 1'b1, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL mulhu_illegal: got ctrl=%h valid=%b ill=%b start=%b expected 0 1 1 0", ctrl, valid, ill, start);
      end
      idle(1);
   endtask

   task automatic test_random();
      logic [6:0] f7;
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0: f7 = 7'b0000000;
            1: f7 = 7'b0100000;
            2: f7 = 7'b0000001;
            default: f7 = 7'($urandom);
         endcase
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 2'($urandom), {f7, 3'($urandom)});
         n_vec++;
         if (act !== expv()) begin n_bad++; $display("FAIL random[%0d]: got %h expected %h", i, act, expv()); end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_rtype_b2b();
      test_itype();
      test_mul();
      test_flush();
      test_enm();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
Registered, handshaked ALU control unit for the multi-cycle and pipelined datapath. It decodes {funct7,funct3} and ALUOp into a 4-bit ALU control code, adding full I-type decode and RV32M support. It sequences variable-latency MUL/DIV operations with a busy/stall FSM, a start pulse, and a flush. It sits between the main Control unit and the ALU / iterative MUL-DIV unit.

Parameters:
CTRL_W, 4, width of ALUCtrl_o; must be >=4; upper bits are zero.
EN_M, 1, 1 enables RV32M decode; 0 makes funct7=0000001 illegal.
MUL_LAT, 3, cycles the MUL/MULH unit is busy; must be >=1.
DIV_LAT, 33, cycles the DIV/DIVU/REM/REMU unit is busy; must be >=1.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
funct_i  in  10  {funct7[6:0], funct3[2:0]}.
ALUOp_i  in  2  00 = ADD (ld/st), 01 = SUB (branch), 10 = R-type, 11 = I-type.
valid_i  in  1  request valid.
flush_i  in  1  synchronous abort.
ready_o  out  1  accept possible; equals (state==IDLE), combinational.
stall_o  out  1  valid_i & ~ready_o, combinational.
ALUCtrl_o  out  CTRL_W  registered control code.
valid_o  out  1  registered; the ALUCtrl_o result is complete this cycle.
start_o  out  1  one-cycle pulse to the MUL/DIV unit.
busy_o  out  1  multi-cycle op in progress.
illegal_o  out  1  registered alongside valid_o; the decode was illegal.

Behaviour:
- Codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL A, MULH B, DIV C, DIVU D, REM E, REMU F.
- ALUOp 00 -> ADD and ALUOp 01 -> SUB; funct_i is ignored for both.
- R-type with funct7 0000000: funct3 000..111 -> ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- R-type with funct7 0100000: funct3 000 -> SUB, 101 -> SRA, else illegal.
- R-type with funct7 0000001 and EN_M=1: 000 MUL, 001 MULH, 100 DIV, 101 DIVU, 110 REM, 111 REMU. 010/011 (MULHSU/MULHU) are illegal.
- Any other R-type funct7 is illegal.
- I-type: funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, with funct7 ignored.
- I-type funct3 001: SLL only if funct7=0000000, else illegal.
- I-type funct3 101: SRL if funct7=0000000, SRA if 0100000, else illegal.
- An illegal decode is treated as a single-cycle op with code ADD and illegal_o=1.
- Accept occurs at edge E0 when valid_i & ready_o & ~flush_i.
- At E0: ALUCtrl_o and illegal_o are loaded. ALUCtrl_o holds until the next accept or reset.
- Single-cycle op: valid_o=1 in the cycle after E0. ready_o stays 1, giving 1 op/cycle throughput; back-to-back accepts keep valid_o high.
- Multi-cycle op, latency L = MUL_LAT for A/B or DIV_LAT for C..F:
  - FSM IDLE -> BUSY at E0; start_o=1 for the cycle after E0 only.
  - Counter loaded with L-1, decremented each edge; width clog2(max(MUL_LAT,DIV_LAT)+1).
  - busy_o=1 and ready_o=0 from after E0 through after E(L-1).
  - At E_L (counter==0): BUSY -> IDLE, valid_o=1 for the cycle after E_L; a new op may be accepted at E_L+1.
- valid_i held high while busy is not accepted, and stall_o=1.
- flush_i at any edge forces IDLE: valid_o, start_o, busy_o and illegal_o go 0 next cycle, and the counter clears. ALUCtrl_o is retained. flush_i with valid_i in IDLE means nothing is accepted. Flush has priority over completion at E_L, so no valid_o is produced.
- Reset (rst_i low, asynchronous, any state, including mid-BUSY): ALUCtrl_o=0, valid_o=0, start_o=0, busy_o=0, illegal_o=0, counter=0, state=IDLE, so ready_o=1 immediately.

Test Plan:
1. Reset: assert rst_i low mid-DIV (3 cycles into DIV_LAT=33) -> same-cycle busy_o=0, ready_o=1, ALUCtrl_o=0. After release, no valid_o appears.
2. R-type back-to-back: ALUOp=10, funct_i=0000000000, then 0100000000, then 0100000101, each on consecutive edges -> ALUCtrl_o=0,1,7 on consecutive cycles, valid_o high for 3 cycles, ready_o never low.
3. I-type/ALUOp=00: ALUOp=11 with 0100000101 -> 7 (SRAI). ALUOp=11 with 0100000000 -> 0. ALUOp=11 with 0100000001 -> illegal_o=1, code 0. ALUOp=00 with 0100000101 -> 0, illegal_o=0.
4. MUL, MUL_LAT=3, funct_i=0000001000, ALUOp=10, valid_i held high -> ALUCtrl_o=A, start_o one cycle, ready_o=0 and stall_o=1 for 3 cycles, valid_o 3 cycles after the first valid_o-slot, then the second request is accepted.
5. Flush: DIVU (0000001101) accepted, flush_i at cycle 5 -> next cycle busy_o=0, ready_o=1, and valid_o is never asserted. flush_i together with valid_i in IDLE -> no accept.
6. EN_M=0: funct_i=0000001000, ALUOp=10 -> single-cycle, illegal_o=1, code 0, no start_o. EN_M=1 with 0000001011 (MULHU) -> illegal_o=1.
